pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch-side program counter with a nested exception-return stack, directly downstream of the monitor/redirect stage. Consumes the redirect request (`J`, `J_R`), the save-return request (`Store_Current`) and the privilege `Mode`. Produces the fetch address for instruction memory, plus a user-mode illegal-PC flag that is fed back to the monitor. Return-from-handler (`Ret`) pops the saved PC so that nested handlers unwind in order.

## Interface
- `RESET_PC`, 16'h0000: PC value after reset.
- `STACK_DEPTH`, 4: return-stack entries; power of two, 2..8.
- `USER_PC_MIN`, 16'h0400: lowest fetch address legal in user mode.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `IFID_Stall` in 1: hold PC.
- `J` in 1: redirect request from the monitor.
- `J_R` in 16: redirect target.
- `Store_Current` in 1: push the current PC onto the return stack with this redirect.
- `Ret` in 1: return-from-handler; pop the stack into the PC.
- `Mode` in 2: privilege; `Mode[1]`=1 means supervisor.
- `PC` out 16: registered fetch address.
- `PC_plus1` out 16: `PC`+1, combinational, modulo 2^16.
- `Illegal_PC` out 1: combinational; user-mode fetch below `USER_PC_MIN`.
- `Depth` out 4: occupied stack entries, 0..`STACK_DEPTH`.
- `Overflow` out 1: sticky; set when a push is made while the stack is full.
- `Underflow` out 1: one-cycle pulse when a pop is made while the stack is empty.

## Operation
- PC update priority, evaluated each rising edge:
  1. `rst`: PC←`RESET_PC`, Depth←0, Overflow←0, Underflow←0, stack contents don't-care.
  2. `J`: PC←`J_R`. If `Store_Current` is also high, push the current PC value (the un-executed instruction) first. `Ret` is ignored in this cycle.
  3. `Ret` with Depth>0: PC←top of stack, Depth−1.
  4. `Ret` with Depth=0: Underflow←1 for one cycle; PC←PC+1 unless `IFID_Stall`.
  5. `IFID_Stall`: PC holds.
  6. Otherwise: PC←PC+1, wrapping 16'hFFFF→16'h0000.
- `J` overrides `IFID_Stall`. The monitor already suppresses `J` during a stall except on a mispredict, which must be honoured.
- `Store_Current` without `J` is ignored (no push).
- Stack is a circular buffer with a top pointer.
  - Push when full: the oldest entry is overwritten, Depth stays at `STACK_DEPTH`, Overflow←1 until reset.
  - A subsequent pop still returns the newest entries in LIFO order.
- `Illegal_PC` = `~Mode[1]` & (PC < `USER_PC_MIN`), unsigned compare. It is 0 in supervisor mode.
- Reset values: PC=`RESET_PC`, PC_plus1=`RESET_PC`+1, Depth=0, Overflow=0, Underflow=0. Illegal_PC is 0 because `Mode` resets to supervisor upstream.

## Timing
- Redirect latency: 1 cycle. `J` sampled high at edge n gives PC=`J_R` after edge n; the fetch at the old PC is squashed upstream.
- Push and redirect complete on the same edge. The pushed value is PC before that edge.
- Pop latency: 1 cycle. A pop and a new push are never merged: `J` wins and `Ret` must be re-presented.
- Reset mid-handler discards all stack contents. No pop is valid afterwards (`Ret` gives Underflow).
- `Illegal_PC` and `PC_plus1` follow `PC` combinationally in the same cycle, with no added latency.
- `Underflow` is high only for the cycle after the offending `Ret` edge.

## Configuration
- `ILLEGAL_PC_CHECK_EN`
  - Defined: `Illegal_PC` computed as above.
  - Undefined: `Illegal_PC` is tied 0, the comparator is not built, and `USER_PC_MIN` is unused.
  - PC/stack behaviour is identical in both cases.

## Test plan
- Reset, then 3 free-running cycles → PC 0x0000, 0x0001, 0x0002, 0x0003; Depth=0.
- PC=0x0205, `J`=1, `J_R`=0x0030, `Store_Current`=1 → next PC=0x0030, Depth=1. `Ret` two cycles later → PC=0x0205, Depth=0.
- 5 nested pushes (PCs 0x10,0x20,0x30,0x40,0x50) with depth 4 → Overflow=1, Depth=4. 4 pops return 0x50,0x40,0x30,0x20; a 5th `Ret` gives Underflow pulse and PC increments.
- `IFID_Stall`=1 with `J`=1, `J_R`=0x1234 → PC=0x1234. Stall alone for 3 cycles → PC holds.
- `Mode`=2'b00, `J` to 0x03FF → `Illegal_PC`=1; next increment to 0x0400 → `Illegal_PC`=0. `Mode`=2'b10 at 0x03FF → 0. With macro undefined → always 0.
- PC=0xFFFF, no stall → PC=0x0000. `J` and `Ret` together with Depth=2 → PC=`J_R`, Depth=2.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch program counter with a circular LIFO of saved return PCs for nested handlers.
// Optional user-mode illegal-PC comparator is built only when ILLEGAL_PC_CHECK_EN is defined.
module pc_sequencer #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          STACK_DEPTH = 4,
    parameter logic [15:0] USER_PC_MIN = 16'h0400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IFID_Stall,
    input  logic        J,
    input  logic [15:0] J_R,
    input  logic        Store_Current,
    input  logic        Ret,
    input  logic [1:0]  Mode,
    output logic [15:0] PC,
    output logic [15:0] PC_plus1,
    output logic        Illegal_PC,
    output logic [3:0]  Depth,
    output logic        Overflow,
    output logic        Underflow
);

    localparam int         PTR_W      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [3:0] DEPTH_FULL = 4'(STACK_DEPTH);

    logic [15:0]      r_pc;
    logic [15:0]      r_stack [STACK_DEPTH];
    logic [PTR_W-1:0] r_top;          // next free slot; newest entry sits at r_top-1
    logic [3:0]       r_depth;
    logic             r_overflow;
    logic             r_underflow;

    logic [15:0]      w_pc_inc;
    logic [15:0]      w_pc_next;
    logic [PTR_W-1:0] w_top_prev;
    logic             w_push;
    logic             w_pop;
    logic             w_pop_empty;

    assign w_pc_inc   = r_pc + 16'd1;
    assign w_top_prev = r_top - PTR_W'(1);

    always_comb begin
        w_push      = J & Store_Current;
        w_pop       = ~J & Ret & (r_depth != 4'd0);
        w_pop_empty = ~J & Ret & (r_depth == 4'd0);
        w_pc_next   = w_pc_inc;
        if (J) begin
            w_pc_next = J_R;
        end else if (w_pop) begin
            w_pc_next = r_stack[w_top_prev];
        end else if (IFID_Stall) begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_top       <= '0;
            r_depth     <= 4'd0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_pc        <= w_pc_next;
            r_underflow <= w_pop_empty;
            if (w_push) begin
                // A full stack wraps onto its oldest slot, so LIFO order of the newest entries survives.
                r_top <= r_top + PTR_W'(1);
                if (r_depth == DEPTH_FULL) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_depth <= r_depth + 4'd1;
                end
            end else if (w_pop) begin
                r_top   <= w_top_prev;
                r_depth <= r_depth - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_stack[r_top] <= r_pc;
        end
    end

    assign PC        = r_pc;
    assign PC_plus1  = w_pc_inc;
    assign Depth     = r_depth;
    assign Overflow  = r_overflow;
    assign Underflow = r_underflow;

`ifdef ILLEGAL_PC_CHECK_EN
    logic w_unused_mode;
    assign w_unused_mode = Mode[0];
    assign Illegal_PC    = ~Mode[1] & (r_pc < USER_PC_MIN);
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{Mode, USER_PC_MIN};
    assign Illegal_PC   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: driver queues hand-computed expectations,
// a monitor checks the DUT state one step after each sampled edge.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        IFID_Stall;
    logic        J;
    logic [15:0] J_R;
    logic        Store_Current;
    logic        Ret;
    logic [1:0]  Mode;
    logic [15:0] PC;
    logic [15:0] PC_plus1;
    logic        Illegal_PC;
    logic [3:0]  Depth;
    logic        Overflow;
    logic        Underflow;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic [3:0]  depth;
        logic        ovf;
        logic        unf;
        logic        ill;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    pc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .IFID_Stall   (IFID_Stall),
        .J            (J),
        .J_R          (J_R),
        .Store_Current(Store_Current),
        .Ret          (Ret),
        .Mode         (Mode),
        .PC           (PC),
        .PC_plus1     (PC_plus1),
        .Illegal_PC   (Illegal_PC),
        .Depth        (Depth),
        .Overflow     (Overflow),
        .Underflow    (Underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input string field, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %h, expected %h", name, field, act, req);
        end
    endtask

    // Monitor: the DUT presents a new state after every edge; compare it against the queued expectation.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            $display("txn %-14s PC=%h Depth=%0d Ovf=%b Unf=%b Ill=%b", e.name, PC, Depth, Overflow, Underflow, Illegal_PC);
            chk(e.name, "PC", PC, e.pc);
            chk(e.name, "PC_plus1", PC_plus1, e.pc + 16'd1);
            chk(e.name, "Depth", {12'd0, Depth}, {12'd0, e.depth});
            chk(e.name, "Overflow", {15'd0, Overflow}, {15'd0, e.ovf});
            chk(e.name, "Underflow", {15'd0, Underflow}, {15'd0, e.unf});
`ifdef ILLEGAL_PC_CHECK_EN
            chk(e.name, "Illegal_PC", {15'd0, Illegal_PC}, {15'd0, e.ill});
`else
            chk(e.name, "Illegal_PC", {15'd0, Illegal_PC}, 16'd0);
`endif
        end
    end

    task automatic step(input string name, input logic r, input logic st, input logic j,
                        input logic [15:0] jr, input logic sc, input logic rt, input logic [1:0] md,
                        input logic [15:0] epc, input logic [3:0] ed, input logic eo,
                        input logic eu, input logic ei);
        exp_t x;
        @(negedge clk);
        rst = r; IFID_Stall = st; J = j; J_R = jr; Store_Current = sc; Ret = rt; Mode = md;
        x.name = name; x.pc = epc; x.depth = ed; x.ovf = eo; x.unf = eu; x.ill = ei;
        q.push_back(x);
    endtask

    initial begin
        rst = 1'b1; IFID_Stall = 1'b0; J = 1'b0; J_R = 16'h0; Store_Current = 1'b0; Ret = 1'b0; Mode = 2'b10;
        //    name           rst st j  jr        sc rt mode   pc        d  o  u  ill
        step("reset0",       1, 0, 0, 16'h0000, 0, 0, 2'b10, 16'h0000, 0, 0, 0, 0);
        step("reset1",       1, 0, 0, 16'h0000, 0, 0, 2'b10, 16'h0000, 0, 0, 0, 0);
        step("free1",        0, 0, 0, 16'h0000, 0, 0, 2'b10, 16'h0001, 0, 0, 0, 0);
        step("free2",        0, 0, 0, 16'h0000, 0, 0, 2'b10, 16'h0002, 0, 0, 0, 0);
        step("free3",        0, 0, 0, 16'h0000, 0, 0, 2'b10, 16'h0003, 0, 0, 0, 0);
        step("jmp205",       0, 0, 1, 16'h0205, 0, 0, 2'b10, 16'h0205, 0, 0, 0, 0);
        step("push205",      0, 0, 1, 16'h0030, 1, 0, 2'b10, 16'h0030, 1, 0, 0, 0);
        step("handler",      0, 0, 0, 16'h0000, 0, 0, 2'b10, 16'h0031, 1, 0, 0, 0);
        step("ret205",       0, 0, 0, 16'h0000, 0, 1, 2'b10, 16'h0205, 0, 0, 0, 0);
        // Five nested pushes into a four-deep stack
        step("jmp10",        0, 0, 1, 16'h0010, 0, 0, 2'b10, 16'h0010, 0, 0, 0, 0);
        step("push10",       0, 0, 1, 16'h0020, 1, 0, 2'b10, 16'h0020, 1, 0, 0, 0);
        step("push20",       0, 0, 1, 16'h0030, 1, 0, 2'b10, 16'h0030, 2, 0, 0, 0);
        step("push30",       0, 0, 1, 16'h0040, 1, 0, 2'b10, 16'h0040, 3, 0, 0, 0);
        step("push40",       0, 0, 1, 16'h0050, 1, 0, 2'b10, 16'h0050, 4, 0, 0, 0);
        step("push50_ovf",   0, 0, 1, 16'h0060, 1, 0, 2'b10, 16'h0060, 4, 1, 0, 0);
        step("pop50",        0, 0, 0, 16'h0000, 0, 1, 2'b10, 16'h0050, 3, 1, 0, 0);
        step("pop40",        0, 0, 0, 16'h0000, 0, 1, 2'b10, 16'h0040, 2, 1, 0, 0);
        step("pop30",        0, 0, 0, 16'h0000, 0, 1, 2'b10, 16'h0030, 1, 1, 0, 0);
        step("pop20",        0, 0, 0, 16'h0000, 0, 1, 2'b10, 16'h0020, 0, 1, 0, 0);
        step("pop_under",    0, 0, 0, 16'h0000, 0, 1, 2'b10, 16'h0021, 0, 1, 1, 0);
        step("under_clr",    0, 0, 0, 16'h0000, 0, 0, 2'b10, 16'h0022, 0, 1, 0, 0);
        step("under_stall",  0, 1, 0, 16'h0000, 0, 1, 2'b10, 16'h0022, 0, 1, 1, 0);
        step("under_clr2",   0, 0, 0, 16'h0000, 0, 0, 2'b10, 16'h0023, 0, 1, 0, 0);
        // Reset in the middle of a handler drops the stack and the sticky overflow
        step("push23",       0, 0, 1, 16'h0100, 1, 0, 2'b10, 16'h0100, 1, 1, 0, 0);
        step("rst_mid",      1, 0, 0, 16'h0000, 0, 0, 2'b10, 16'h0000, 0, 0, 0, 0);
        step("ret_after_rst",0, 0, 0, 16'h0000, 0, 1, 2'b10, 16'h0001, 0, 0, 1, 0);
        // Mispredict redirect during a stall, then a held stall
        step("stall_jmp",    0, 1, 1, 16'h1234, 0, 0, 2'b10, 16'h1234, 0, 0, 0, 0);
        step("stall1",       0, 1, 0, 16'h0000, 0, 0, 2'b10, 16'h1234, 0, 0, 0, 0);
        step("stall2",       0, 1, 0, 16'h0000, 0, 0, 2'b10, 16'h1234, 0, 0, 0, 0);
        step("stall3",       0, 1, 0, 16'h0000, 0, 0, 2'b10, 16'h1234, 0, 0, 0, 0);
        // User-mode boundary around 0x0400
        step("user_3ff",     0, 0, 1, 16'h03FF, 0, 0, 2'b00, 16'h03FF, 0, 0, 0, 1);
        step("user_400",     0, 0, 0, 16'h0000, 0, 0, 2'b00, 16'h0400, 0, 0, 0, 0);
        step("user_3ff_b",   0, 0, 1, 16'h03FF, 0, 0, 2'b00, 16'h03FF, 0, 0, 0, 1);
        step("super_3ff",    0, 1, 0, 16'h0000, 0, 0, 2'b10, 16'h03FF, 0, 0, 0, 0);
        step("user_low0",    0, 0, 1, 16'h0000, 0, 0, 2'b01, 16'h0000, 0, 0, 0, 1);
        // 16-bit wrap
        step("jmp_ffff",     0, 0, 1, 16'hFFFF, 0, 0, 2'b10, 16'hFFFF, 0, 0, 0, 0);
        step("wrap",         0, 0, 0, 16'h0000, 0, 0, 2'b10, 16'h0000, 0, 0, 0, 0);
        // Redirect beats a simultaneous return
        step("push0000",     0, 0, 1, 16'h0500, 1, 0, 2'b10, 16'h0500, 1, 0, 0, 0);
        step("push0500",     0, 0, 1, 16'h0600, 1, 0, 2'b10, 16'h0600, 2, 0, 0, 0);
        step("j_and_ret",    0, 0, 1, 16'h0700, 0, 1, 2'b10, 16'h0700, 2, 0, 0, 0);
        step("ret0500",      0, 0, 0, 16'h0000, 0, 1, 2'b10, 16'h0500, 1, 0, 0, 0);
        step("ret0000",      0, 0, 0, 16'h0000, 0, 1, 2'b10, 16'h0000, 0, 0, 0, 0);
        // Store_Current without J must not push
        step("sc_alone",     0, 0, 0, 16'h0000, 1, 0, 2'b10, 16'h0001, 0, 0, 0, 0);
        step("sc_alone_ret", 0, 0, 0, 16'h0000, 0, 1, 2'b10, 16'h0002, 0, 0, 1, 0);

        @(negedge clk);
        Ret = 1'b0; Store_Current = 1'b0; J = 1'b0;
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(negedge clk);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
